aes_enc_ctrl: RTL and testbench

Iterative AES-128 encryption controller that sequences one shared round datapath: sub_bytes -> shift_rows -> mix_columns -> add_round_key.
- Runs 10 rounds, one per clock, and expands round keys on the fly (no key RAM).
- Accepts one plaintext/key pair through a valid/ready input handshake and returns the ciphertext through a valid/ready output handshake.
- Top-level encryption engine of the aes_128 project; wraps the existing combinational round primitives.

---
 rtl/aes_const_pack.sv | 52 +++++
 rtl/aes_model_pack.sv | 31 +++
 rtl/aes_enc_ctrl_round.sv | 44 ++++
 rtl/aes_enc_ctrl.sv | 149 ++++++++++++++
 tb/tb_aes_enc_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/aes_const_pack.sv
// AES-128 constant tables: S-box, round constants and default round count.
// Pure functions only; no state.
package aes_const_pack;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int CLK_FREQ       = 100_000_000;

    // Byte i of the S-box sits at bits [2047-8*i -: 8], rows of 16 entries.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX_TBL[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_model_pack.sv
// AES state representation: column-major 4x4 byte table plus GF(2^8) helpers.
// Vector byte k maps to row k%4, column k/4.
package aes_model_pack;

    typedef logic [7:0]             byte_t;
    typedef logic [31:0]            word_t;
    typedef logic [3:0][3:0][7:0]   byte_table_t;

    function automatic byte_table_t vec_to_table(input logic [127:0] v);
        byte_table_t t;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            t[k % 4][k / 4] = v[127 - 8*k -: 8];
        end
        return t;
    endfunction

    function automatic logic [127:0] table_to_vec(input byte_table_t t);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            v[127 - 8*k -: 8] = t[k % 4][k / 4];
        end
        return v;
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_round.sv
// One AES round: sub_bytes -> shift_rows -> mix_columns (skippable) -> add_round_key.
// Purely combinational, zero latency; no flow control.
module aes_round
    import aes_model_pack::*;
    import aes_const_pack::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         skip_mix_i,
    output logic [127:0] state_o
);

    byte_table_t st;
    byte_table_t sb;
    byte_table_t sh;
    byte_table_t mx;

    always_comb begin
        st = vec_to_table(state_i);
        sb = '0;
        sh = '0;
        mx = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sb[r][c] = sbox(st[r][c]);
            end
        end
        // Row r rotates left by r positions.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sh[r][c] = sb[r][(c + r) % 4];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mx[0][c] = xtime(sh[0][c]) ^ xtime(sh[1][c]) ^ sh[1][c] ^ sh[2][c] ^ sh[3][c];
            mx[1][c] = sh[0][c] ^ xtime(sh[1][c]) ^ xtime(sh[2][c]) ^ sh[2][c] ^ sh[3][c];
            mx[2][c] = sh[0][c] ^ sh[1][c] ^ xtime(sh[2][c]) ^ xtime(sh[3][c]) ^ sh[3][c];
            mx[3][c] = xtime(sh[0][c]) ^ sh[0][c] ^ sh[1][c] ^ sh[2][c] ^ xtime(sh[3][c]);
        end
    end

    assign state_o = table_to_vec(skip_mix_i ? sh : mx) ^ round_key_i;

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Latency: out_valid rises 10 cycles after the accepting edge; 11-cycle block period back-to-back.
// Backpressure: result held in DONE until out_ready; in_ready low while busy or held result.
module aes_enc_ctrl
    import aes_model_pack::*;
    import aes_const_pack::*;
#(
    parameter int NUM_ROUNDS   = AES_NUM_ROUNDS,
    parameter int BACK_TO_BACK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [3:0]   round_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_e;

    localparam logic [3:0] LAST_MIX_RND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_RND    = 4'(NUM_ROUNDS);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_block_q, out_block_d;

    logic         accept;
    logic [127:0] rk_next;
    logic [127:0] round_out;
    word_t        w0, w1, w2, w3;
    word_t        sub_rot;
    word_t        n0, n1, n2, n3;

    // Round key schedule, one step per round; rcon is indexed by round_cnt-1.
    assign w0      = rk_q[127:96];
    assign w1      = rk_q[95:64];
    assign w2      = rk_q[63:32];
    assign w3      = rk_q[31:0];
    assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0      = w0 ^ sub_rot ^ {rcon(round_cnt_q - 4'd1), 24'h000000};
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    aes_round u_round (
        .state_i     (state_q),
        .round_key_i (rk_next),
        .skip_mix_i  (fsm_q == S_FINAL),
        .state_o     (round_out)
    );

    // out_ready feeds in_ready combinationally so DONE can hand over in a single edge.
    assign in_ready = (fsm_q == S_IDLE) ||
                      ((BACK_TO_BACK != 0) && (fsm_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_d        = rk_q;
        round_cnt_d = round_cnt_q;
        out_valid_d = out_valid_q;
        out_block_d = out_block_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = in_block ^ in_key;
                    rk_d        = in_key;
                    round_cnt_d = 4'd1;
                    fsm_d       = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d     = round_out;
                rk_d        = rk_next;
                round_cnt_d = round_cnt_q + 4'd1;
                if (round_cnt_q == LAST_MIX_RND) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d     = round_out;
                rk_d        = rk_next;
                out_block_d = round_out;
                out_valid_d = 1'b1;
                round_cnt_d = FINAL_RND;
                fsm_d       = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        state_d     = in_block ^ in_key;
                        rk_d        = in_key;
                        round_cnt_d = 4'd1;
                        fsm_d       = S_ROUND;
                    end else begin
                        round_cnt_d = 4'd0;
                        fsm_d       = S_IDLE;
                    end
                end
            end
            default: begin
                fsm_d       = S_IDLE;
                round_cnt_d = 4'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            round_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rk_q        <= rk_d;
            round_cnt_q <= round_cnt_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_FINAL);
    assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl using FIPS-197 vectors.
module tb_aes_enc_ctrl;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [3:0]   round_cnt;

    int n_checks = 0;
    int n_errors = 0;

    aes_enc_ctrl #(
        .NUM_ROUNDS   (10),
        .BACK_TO_BACK (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [127:0] blk, input logic [127:0] key);
        in_valid = 1'b1;
        in_block = blk;
        in_key   = key;
        tick();
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; waits (bounded) for out_valid.
    task automatic wait_result(input string tag, input logic [127:0] exp,
                               input bit chk_rc, input bit churn);
        int cyc;
        int exp_rc;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (churn) begin
                in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick();
            cyc++;
            if (chk_rc) begin
                exp_rc = (cyc + 1 > 10) ? 10 : cyc + 1;
                check_val({tag, "_rc"}, round_cnt, exp_rc);
                check_val({tag, "_busy"}, busy, (cyc < 10) ? 1 : 0);
            end
        end
        check_val({tag, "_lat"}, cyc, 10);
        check_val({tag, "_ct"}, out_block, exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_block", out_block, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_round_cnt", round_cnt, 0);
        rst = 1'b0;
        tick();

        // App. B with the result held under backpressure
        start_block(PT_B, KEY_B);
        check_val("appb_busy0", busy, 1);
        check_val("appb_rc0", round_cnt, 1);
        wait_result("appb", CT_B, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_out_block", out_block, CT_B);
        end

        // Back-to-back: consume App. B and accept C.1 on the same edge
        in_valid  = 1'b1;
        in_block  = PT_C;
        in_key    = KEY_C;
        out_ready = 1'b1;
        #1;
        check_val("b2b_in_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("b2b_out_valid", out_valid, 0);
        check_val("b2b_busy", busy, 1);
        check_val("b2b_rc", round_cnt, 1);
        wait_result("c1_b2b", CT_C, 1'b1, 1'b0);

        // Plain consume returns to IDLE
        out_ready = 1'b1;
        #1;
        check_val("done_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b0;
        check_val("idle_out_valid", out_valid, 0);
        check_val("idle_rc", round_cnt, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_in_ready", in_ready, 1);

        // Input churn while busy
        start_block(PT_C, KEY_C);
        wait_result("churn", CT_C, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of round 5
        start_block(PT_B, KEY_B);
        repeat (4) tick();
        check_val("mid_rc_before", round_cnt, 5);
        rst = 1'b1;
        #1;
        check_val("mid_out_valid", out_valid, 0);
        check_val("mid_busy", busy, 0);
        check_val("mid_in_ready", in_ready, 1);
        check_val("mid_rc", round_cnt, 0);
        check_val("mid_out_block", out_block, 0);
        @(negedge clk);
        rst = 1'b0;
        start_block(PT_B, KEY_B);
        wait_result("appb_after_rst", CT_B, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("final_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
